// File: rtl/wave_rom_sequencer.sv
// Walks a waveform ROM by programmable phase/step and streams a frame of samples over valid/ready.
// Build option: WAVE_SEQ_SIGNED_EN converts offset-binary ROM bytes to two's complement at FIFO write.
module wave_rom_sequencer #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_phase,
    input  logic [ADDR_WIDTH-1:0] step,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Read pipeline: stage 1 = address presented, stage 2 = ROM data on rom_rd_data
    logic                  rd_vld1_q, rd_vld1_d;
    logic                  rd_last1_q, rd_last1_d;
    logic                  rd_vld2_q, rd_vld2_d;
    logic                  rd_last2_q, rd_last2_d;

    logic [DATA_WIDTH:0]   fifo_mem_q [4];
    logic [DATA_WIDTH:0]   fifo_mem_d [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            fifo_count_q, fifo_count_d;

    logic [2:0]            occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rom_sample;
    logic [DATA_WIDTH:0]   fifo_head;

`ifdef WAVE_SEQ_SIGNED_EN
    assign rom_sample = {~rom_rd_data[DATA_WIDTH-1], rom_rd_data[DATA_WIDTH-2:0]};
`else
    assign rom_sample = rom_rd_data;
`endif

    // Credit counts reads still in the ROM pipeline so the FIFO can never overflow
    assign occupancy = fifo_count_q + {2'b00, rd_vld1_q} + {2'b00, rd_vld2_q};
    assign issue     = (state_q == RUN) && (issue_left_q != '0) && (occupancy < 3'd4);
    assign push      = rd_vld2_q;
    assign pop       = (fifo_count_q != '0) && m_ready;
    assign fifo_head = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        rom_addr_d   = rom_addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        rd_vld1_d    = issue;
        rd_last1_d   = issue && (issue_left_q == LEN_WIDTH'(1));
        rd_vld2_d    = rd_vld1_q;
        rd_last2_d   = rd_last1_q;

        if (pop) begin
            out_left_d = out_left_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    phase_d      = start_phase;
                    step_d       = step;
                    issue_left_d = frame_len;
                    out_left_d   = frame_len;
                    busy_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    rom_addr_d   = phase_q;
                    phase_d      = phase_q + step_q;
                    issue_left_d = issue_left_q - 1'b1;
                    if (issue_left_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (out_left_q == LEN_WIDTH'(1))) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {rd_last2_q, rom_sample};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            step_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            rom_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_vld1_q    <= 1'b0;
            rd_last1_q   <= 1'b0;
            rd_vld2_q    <= 1'b0;
            rd_last2_q   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            rom_addr_q   <= rom_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_vld1_q    <= rd_vld1_d;
            rd_last1_q   <= rd_last1_d;
            rd_vld2_q    <= rd_vld2_d;
            rd_last2_q   <= rd_last2_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign m_valid  = (fifo_count_q != '0);
    // Head is masked while empty so stale entries never leak onto the bus
    assign m_data   = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last   = m_valid & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_wave_rom_sequencer.sv
// Self-checking bench for wave_rom_sequencer: ROM model mem[i]=i, sample-queue model, directed frames.
module tb_wave_rom_sequencer;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 10;
`ifdef WAVE_SEQ_SIGNED_EN
    localparam logic [DW-1:0] SFLIP = 8'h80;
`else
    localparam logic [DW-1:0] SFLIP = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_phase;
    logic [AW-1:0] step;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] rom_mem [128];

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] got_q [$];
    bit            done_exp;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    wave_rom_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_phase(start_phase),
        .step       (step),
        .frame_len  (frame_len),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_rd_data(rom_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rd_data <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sample k of a frame reads (phase + k*step) mod 128; last flag on k = len-1
    function automatic logic [DW:0] model_sample(input logic [AW-1:0] ph, input logic [AW-1:0] st,
                                                 input logic [LW-1:0] len, input int k);
        int addr;
        logic [DW-1:0] d;
        addr = (int'(ph) + k * int'(st)) % 128;
        d = DW'(addr) ^ SFLIP;
        return {(k == int'(len) - 1), d};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] ph, input logic [AW-1:0] st,
                               input logic [LW-1:0] len, input bit accept);
        start       = 1'b1;
        start_phase = ph;
        step        = st;
        frame_len   = len;
        if (accept) begin
            for (int k = 0; k < int'(len); k++) exp_q.push_back(model_sample(ph, st, len, k));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < maxc) begin
            cycles(1);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending samples expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
    endtask

    // Compare process: every handshake against the model queue, done timing, stall stability
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                done_exp   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("done", done, done_exp);
                if (done_exp) check("busy_after_done", busy, 0);
                done_exp = 1'b0;
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_sample: got 0x%0h expected none at %0t", m_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e[DW-1:0]);
                        check("m_last", m_last, e[DW]);
                        done_exp = e[DW];
                        got_q.push_back(m_data);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        int n;
        int issues;
        int max_out;
        logic [AW-1:0] last_addr;
        logic [DW-1:0] wrap_lit [4];
`ifdef WAVE_SEQ_SIGNED_EN
        wrap_lit = '{8'hF8, 8'hFD, 8'h82, 8'h87};
`else
        wrap_lit = '{8'd120, 8'd125, 8'd2, 8'd7};
`endif
        for (int i = 0; i < 128; i++) rom_mem[i] = DW'(i);
        rst = 1'b1; start = 1'b0; start_phase = '0; step = '0; frame_len = '0; m_ready = 1'b1;
        #2;
        check_outputs_zero("reset");
        cycles(2);
        rst = 1'b0;
        cycles(2);

        // Basic frame: latency, one sample per cycle, done timing
        got_q.delete();
        pulse_start(7'd0, 7'd1, 10'd8, 1'b1);
        check("basic_busy", busy, 1);
        check("basic_valid_e0", m_valid, 0);
        cycles(1);
        check("basic_valid_e1", m_valid, 0);
        check("basic_addr_e1", rom_addr, 0);
        cycles(1);
        check("basic_valid_e2", m_valid, 0);
        check("basic_addr_e2", rom_addr, 1);
        cycles(1);
        check("basic_valid_e3", m_valid, 1);
        check("basic_data_e3", m_data, SFLIP);
        n = 3;
        while (!done && n < 40) begin
            cycles(1);
            n++;
        end
        check("basic_done_edge", n, 11);
        cycles(1);
        check("basic_busy_low", busy, 0);
        check("basic_done_low", done, 0);
        wait_idle("basic", 50);
        check("basic_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("basic_lit", got_q[i], DW'(i) ^ SFLIP);

        // Wrap and step
        got_q.delete();
        pulse_start(7'd120, 7'd5, 10'd4, 1'b1);
        wait_idle("wrap", 50);
        check("wrap_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("wrap_lit", got_q[i], wrap_lit[i]);

        // Ignored starts: zero length, and a start during a running frame
        pulse_start(7'd5, 7'd1, 10'd0, 1'b0);
        check("zero_len_busy", busy, 0);
        cycles(3);
        check("zero_len_busy_later", busy, 0);
        check("zero_len_valid", m_valid, 0);
        got_q.delete();
        pulse_start(7'd0, 7'd1, 10'd8, 1'b1);
        cycles(2);
        pulse_start(7'd50, 7'd3, 10'd5, 1'b0);
        check("midframe_busy", busy, 1);
        wait_idle("midframe", 60);
        cycles(6);
        check("midframe_count", got_q.size(), 8);
        check("midframe_busy_end", busy, 0);

        // Backpressure with random 30% ready and two 10-cycle stalls; track outstanding reads
        got_q.delete();
        last_addr = rom_addr;
        issues = 0;
        max_out = 0;
        pulse_start(7'd0, 7'd1, 10'd16, 1'b1);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            if (rom_addr != last_addr) issues++;
            last_addr = rom_addr;
            if (issues - got_q.size() > max_out) max_out = issues - got_q.size();
            if ((n >= 5 && n < 15) || (n >= 30 && n < 40)) m_ready = 1'b0;
            else m_ready = ($urandom_range(0, 99) < 30);
            cycles(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL bp_timeout: got %0d pending samples expected 0", exp_q.size());
        end
        m_ready = 1'b1;
        check("bp_count", got_q.size(), 16);
        check("bp_issues", issues, 16);
        checks++;
        if (max_out > 4) begin
            errors++;
            $display("FAIL bp_occupancy: got %0d outstanding expected at most 4", max_out);
        end
        cycles(2);

        // Reset mid-frame
        got_q.delete();
        pulse_start(7'd0, 7'd1, 10'd16, 1'b1);
        n = 0;
        while (got_q.size() < 5 && n < 50) begin
            cycles(1);
            n++;
        end
        check("rst_mid_reached", (got_q.size() >= 5), 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        cycles(2);
        rst = 1'b0;
        cycles(4);
        check("rst_mid_busy", busy, 0);
        got_q.delete();
        pulse_start(7'd0, 7'd2, 10'd3, 1'b1);
        wait_idle("post_rst", 50);
        check("post_rst_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("post_rst_lit", got_q[i], DW'(2 * i) ^ SFLIP);

        // Back-to-back: second start issued in the done cycle
        got_q.delete();
        pulse_start(7'd10, 7'd3, 10'd5, 1'b1);
        n = 0;
        while (!done && n < 40) begin
            cycles(1);
            n++;
        end
        check("b2b_done_seen", done, 1);
        pulse_start(7'd100, 7'd7, 10'd5, 1'b1);
        check("b2b_busy", busy, 1);
        cycles(2);
        check("b2b_valid_e2", m_valid, 0);
        cycles(1);
        check("b2b_valid_e3", m_valid, 1);
        check("b2b_first", m_data, 8'd100 ^ SFLIP);
        wait_idle("b2b", 60);
        check("b2b_count", got_q.size(), 10);
        if (got_q.size() == 10) check("b2b_wrap_last", got_q[9], SFLIP);
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
